// File: rtl/uart_rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_frame_ctrl
//
// Assembles 4-byte command frames (SYNC, CMD, ARG, CHK with CHK = CMD ^ ARG)
// from the UART receiver's per-byte completion pulses. It enforces an
// inter-byte timeout, validates the checksum and hands good CMD/ARG pairs to
// the command decoder through a one-entry valid/ready output register.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   rx_data    received byte, qualified by rx_done
//   rx_done    one-cycle pulse per received byte
//   rx_error   receiver parity/stop error on this byte (qualified by rx_done)
//   cmd, arg   validated command / argument bytes
//   cmd_valid  cmd/arg hold a frame not yet accepted
//   cmd_ready  decoder accepts cmd/arg when cmd_valid is also high
//   frame_err  one-cycle error pulse
//   err_code   error cause: 01 rx error, 10 timeout, 11 checksum, 00 overrun
//   busy       high while a frame is being assembled
// -----------------------------------------------------------------------------
module uart_rx_frame_ctrl #(
   parameter logic [7:0] SYNC_BYTE      = 8'hA5,
   parameter int         TIMEOUT_CYCLES = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_done,
   input  logic       rx_error,
   output logic [7:0] cmd,
   output logic [7:0] arg,
   output logic       cmd_valid,
   input  logic       cmd_ready,
   output logic       frame_err,
   output logic [1:0] err_code,
   output logic       busy
);

   localparam int            CW       = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

   typedef enum logic [1:0] {
      WAIT_SYNC = 2'd0,
      GET_CMD   = 2'd1,
      GET_ARG   = 2'd2,
      GET_CHK   = 2'd3
   } state_t;

   state_t        state_r;
   state_t        state_next_s;
   logic [CW-1:0] tmo_cnt_r;
   logic [7:0]    cmd_cap_r;
   logic [7:0]    arg_cap_r;
   logic          cap_cmd_s;
   logic          cap_arg_s;
   logic          good_s;
   logic          load_s;
   logic          err_s;
   logic [1:0]    err_code_s;

   // Expected check byte of a frame.
   function automatic logic [7:0] frame_chk(input logic [7:0] c, input logic [7:0] a);
      return c ^ a;
   endfunction

   // Frame state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= WAIT_SYNC;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state decode, byte capture strobes and error selection.
   // rx error and checksum/overrun need rx_done=1 while timeout needs rx_done=0,
   // so the error priority falls out of the branch structure.
   always_comb begin
      state_next_s = state_r;
      cap_cmd_s    = 1'b0;
      cap_arg_s    = 1'b0;
      good_s       = 1'b0;
      load_s       = 1'b0;
      err_s        = 1'b0;
      err_code_s   = 2'b00;
      if (rx_done) begin
         if (rx_error) begin
            state_next_s = WAIT_SYNC;
            err_s        = 1'b1;
            err_code_s   = 2'b01;
         end else begin
            case (state_r)
               WAIT_SYNC: begin
                  if (rx_data == SYNC_BYTE) begin
                     state_next_s = GET_CMD;
                  end else begin
                     state_next_s = WAIT_SYNC;
                  end
               end
               GET_CMD: begin
                  cap_cmd_s    = 1'b1;
                  state_next_s = GET_ARG;
               end
               GET_ARG: begin
                  cap_arg_s    = 1'b1;
                  state_next_s = GET_CHK;
               end
               GET_CHK: begin
                  state_next_s = WAIT_SYNC;
                  if (rx_data == frame_chk(cmd_cap_r, arg_cap_r)) begin
                     good_s = 1'b1;
                  end else begin
                     err_s      = 1'b1;
                     err_code_s = 2'b11;
                  end
               end
               default: begin
                  state_next_s = WAIT_SYNC;
               end
            endcase
         end
      end else if ((state_r != WAIT_SYNC) && (tmo_cnt_r == CNT_LAST)) begin
         state_next_s = WAIT_SYNC;
         err_s        = 1'b1;
         err_code_s   = 2'b10;
      end else begin
         state_next_s = state_r;
      end

      // A good frame loads only if the output slot is empty or being drained now.
      if (good_s) begin
         if (cmd_valid && !cmd_ready) begin
            err_s      = 1'b1;
            err_code_s = 2'b00;
         end else begin
            load_s = 1'b1;
         end
      end else begin
         load_s = 1'b0;
      end
   end

   // Inter-byte timeout counter; saturates rather than wrapping.
   always_ff @(posedge clk) begin
      if (reset) begin
         tmo_cnt_r <= {CW{1'b0}};
      end else if (rx_done || (state_r == WAIT_SYNC) || (state_next_s == WAIT_SYNC)) begin
         tmo_cnt_r <= {CW{1'b0}};
      end else if (tmo_cnt_r != CNT_MAX) begin
         tmo_cnt_r <= tmo_cnt_r + CNT_ONE;
      end
   end

   // CMD/ARG capture registers for the frame in progress.
   always_ff @(posedge clk) begin
      if (reset) begin
         cmd_cap_r <= 8'h00;
         arg_cap_r <= 8'h00;
      end else begin
         if (cap_cmd_s) begin
            cmd_cap_r <= rx_data;
         end
         if (cap_arg_s) begin
            arg_cap_r <= rx_data;
         end
      end
   end

   // Registered outputs: decoder slot, error pulse/code and busy flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         cmd       <= 8'h00;
         arg       <= 8'h00;
         cmd_valid <= 1'b0;
         frame_err <= 1'b0;
         err_code  <= 2'b00;
         busy      <= 1'b0;
      end else begin
         busy      <= (state_next_s != WAIT_SYNC);
         frame_err <= err_s;
         if (err_s) begin
            err_code <= err_code_s;
         end
         if (load_s) begin
            cmd       <= cmd_cap_r;
            arg       <= arg_cap_r;
            cmd_valid <= 1'b1;
         end else if (cmd_valid && cmd_ready) begin
            cmd_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for uart_rx_frame_ctrl: a queue-based frame model predicts every
// output each cycle, directed scenarios pin key values with literals, and a
// randomized phase exercises frames, junk, errors, long gaps and backpressure.
// -----------------------------------------------------------------------------
module tb_uart_rx_frame_ctrl;

   localparam logic [7:0] SYNC = 8'hA5;
   localparam int         TMO  = 64;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] rx_data;
   logic       rx_done;
   logic       rx_error;
   logic [7:0] cmd;
   logic [7:0] arg;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       frame_err;
   logic [1:0] err_code;
   logic       busy;

   int checks = 0;
   int errors = 0;
   bit armed  = 1'b0;

   uart_rx_frame_ctrl #(.SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
      .rx_error(rx_error), .cmd(cmd), .arg(arg), .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready), .frame_err(frame_err), .err_code(err_code),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [7:0] mq[$];       // bytes of the frame in progress (SYNC, CMD, ARG)
   int         gap;         // cycles since the last received byte
   logic [7:0] m_cmd, m_arg;
   logic       m_valid, m_err, m_busy;
   logic [1:0] m_code;

   always @(posedge clk) begin
      bit         err;
      bit         good;
      logic [1:0] code;
      err  = 1'b0;
      good = 1'b0;
      code = 2'b00;
      if (reset) begin
         mq.delete();
         gap = 0;
         m_cmd = 8'h00; m_arg = 8'h00; m_valid = 1'b0;
         m_err = 1'b0;  m_code = 2'b00; m_busy = 1'b0;
      end else begin
         if (rx_done) begin
            gap = 0;
            if (rx_error) begin
               err = 1'b1; code = 2'b01; mq.delete();
            end else if (mq.size() == 0) begin
               if (rx_data == SYNC) mq.push_back(rx_data);
            end else if (mq.size() < 3) begin
               mq.push_back(rx_data);
            end else begin
               if (rx_data == (mq[1] ^ mq[2])) good = 1'b1;
               else begin err = 1'b1; code = 2'b11; end
               if (good) begin
                  if (m_valid && !cmd_ready) begin
                     err = 1'b1; code = 2'b00;
                  end else begin
                     m_cmd = mq[1]; m_arg = mq[2]; m_valid = 1'b1;
                  end
               end
               mq.delete();
            end
         end else if (mq.size() > 0) begin
            gap++;
            if (gap >= TMO) begin
               err = 1'b1; code = 2'b10; mq.delete(); gap = 0;
            end
         end
         if (!good && m_valid && cmd_ready) m_valid = 1'b0;
         m_err  = err;
         if (err) m_code = code;
         m_busy = (mq.size() > 0);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Cycle-by-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (armed) begin
         chk("cmd_valid", {31'd0, cmd_valid}, {31'd0, m_valid});
         chk("cmd",       {24'd0, cmd},       {24'd0, m_cmd});
         chk("arg",       {24'd0, arg},       {24'd0, m_arg});
         chk("frame_err", {31'd0, frame_err}, {31'd0, m_err});
         chk("err_code",  {30'd0, err_code},  {30'd0, m_code});
         chk("busy",      {31'd0, busy},      {31'd0, m_busy});
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input logic e);
      rx_data = b; rx_done = 1'b1; rx_error = e;
      tick();
      rx_done = 1'b0; rx_error = 1'b0; rx_data = 8'($urandom);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] k);
      send(SYNC, 1'b0); send(c, 1'b0); send(a, 1'b0); send(k, 1'b0);
   endtask

   initial begin
      reset = 1'b1; rx_data = 8'h00; rx_done = 1'b0; rx_error = 1'b0; cmd_ready = 1'b0;
      tick(); tick();
      armed = 1'b1;
      chk("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
      chk("rst_busy",      {31'd0, busy},      32'd0);
      chk("rst_err_code",  {30'd0, err_code},  32'd0);
      reset = 1'b0;
      tick();

      // 1: good frame, delivered one cycle after CHK, held one cycle
      cmd_ready = 1'b1;
      frame(8'h12, 8'h34, 8'h26);
      chk("t1_valid", {31'd0, cmd_valid}, 32'd1);
      chk("t1_cmd",   {24'd0, cmd},       32'h12);
      chk("t1_arg",   {24'd0, arg},       32'h34);
      chk("t1_noerr", {31'd0, frame_err}, 32'd0);
      tick();
      chk("t1_drop",  {31'd0, cmd_valid}, 32'd0);

      // 2: bad checksum, then a good frame
      frame(8'h12, 8'h34, 8'h27);
      chk("t2_err",   {31'd0, frame_err}, 32'd1);
      chk("t2_code",  {30'd0, err_code},  32'd3);
      chk("t2_novld", {31'd0, cmd_valid}, 32'd0);
      tick();
      chk("t2_pulse", {31'd0, frame_err}, 32'd0);
      chk("t2_hold",  {30'd0, err_code},  32'd3);
      frame(8'h01, 8'h02, 8'h03);
      chk("t2_cmd",   {24'd0, cmd},       32'h01);
      chk("t2_valid", {31'd0, cmd_valid}, 32'd1);
      tick();

      // 3: timeout after 64 idle cycles; byte on the last cycle wins
      send(SYNC, 1'b0); send(8'h12, 1'b0);
      idle(TMO - 1);
      chk("t3_nottmo", {31'd0, frame_err}, 32'd0);
      chk("t3_busy",   {31'd0, busy},      32'd1);
      tick();
      chk("t3_tmo",    {31'd0, frame_err}, 32'd1);
      chk("t3_code",   {30'd0, err_code},  32'd2);
      chk("t3_idle",   {31'd0, busy},      32'd0);
      send(SYNC, 1'b0); send(8'h12, 1'b0);
      idle(TMO - 1);
      send(8'h34, 1'b0);
      chk("t3_bytewin", {31'd0, frame_err}, 32'd0);
      send(8'h26, 1'b0);
      chk("t3_dlv",     {31'd0, cmd_valid}, 32'd1);
      tick();

      // 4: rx error aborts; junk before SYNC ignored
      send(SYNC, 1'b0); send(8'h12, 1'b0); send(8'h34, 1'b1);
      chk("t4_err",  {31'd0, frame_err}, 32'd1);
      chk("t4_code", {30'd0, err_code},  32'd1);
      chk("t4_idle", {31'd0, busy},      32'd0);
      send(8'h34, 1'b0);
      chk("t4_ign",  {31'd0, busy},      32'd0);
      send(8'h00, 1'b0); send(8'hFF, 1'b0);
      frame(8'h56, 8'h78, 8'h2E);
      chk("t4_cmd",  {24'd0, cmd},       32'h56);
      chk("t4_arg",  {24'd0, arg},       32'h78);
      tick();

      // 5: overrun with backpressure, then simultaneous consume/load
      cmd_ready = 1'b0;
      frame(8'h10, 8'h01, 8'h11);
      frame(8'h20, 8'h02, 8'h22);
      chk("t5_ovr",   {31'd0, frame_err}, 32'd1);
      chk("t5_code",  {30'd0, err_code},  32'd0);
      chk("t5_keep",  {24'd0, cmd},       32'h10);
      chk("t5_valid", {31'd0, cmd_valid}, 32'd1);
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      frame(8'h10, 8'h01, 8'h11);
      send(SYNC, 1'b0); send(8'h20, 1'b0); send(8'h02, 1'b0);
      cmd_ready = 1'b1;
      send(8'h22, 1'b0);
      chk("t5_swap",  {24'd0, cmd},       32'h20);
      chk("t5_noerr", {31'd0, frame_err}, 32'd0);
      chk("t5_vld2",  {31'd0, cmd_valid}, 32'd1);
      tick();

      // 6: reset mid-frame and while holding a frame
      send(SYNC, 1'b0); send(8'h12, 1'b0);
      reset = 1'b1; tick(); reset = 1'b0;
      chk("t6_busy", {31'd0, busy}, 32'd0);
      cmd_ready = 1'b0;
      frame(8'h10, 8'h01, 8'h11);
      reset = 1'b1; tick(); reset = 1'b0;
      chk("t6_valid", {31'd0, cmd_valid}, 32'd0);
      chk("t6_cmd",   {24'd0, cmd},       32'd0);
      cmd_ready = 1'b1;
      frame(8'h33, 8'h44, 8'h77);
      chk("t6_cmd2",  {24'd0, cmd},       32'h33);
      chk("t6_arg2",  {24'd0, arg},       32'h44);
      tick();

      // Randomized traffic: frames, junk, errors, long gaps, random backpressure
      for (int it = 0; it < 500; it++) begin
         int          kind;
         logic [7:0]  c, a, k;
         kind = int'($urandom_range(0, 9));
         c = 8'($urandom); a = 8'($urandom);
         k = (kind == 1) ? (c ^ a ^ 8'(1 + $urandom_range(0, 254))) : (c ^ a);
         for (int b = 0; b < 4; b++) begin
            logic [7:0] byt;
            int         g;
            byt = (b == 0) ? SYNC : (b == 1) ? c : (b == 2) ? a : k;
            if (kind == 2) byt = 8'($urandom);
            cmd_ready = 1'($urandom);
            send(byt, (kind == 3 && $urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
            g = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TMO - 4, TMO + 1))
                                            : int'($urandom_range(0, 2));
            for (int j = 0; j < g; j++) begin
               cmd_ready = 1'($urandom);
               tick();
            end
         end
         if ($urandom_range(0, 99) == 0) begin
            reset = 1'b1; tick(); reset = 1'b0;
         end
      end

      cmd_ready = 1'b1;
      idle(4);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
- Sits between the UART byte receiver and the command decoder.
- Consumes the receiver's per-byte completion pulses and assembles 4-byte command frames: SYNC, CMD, ARG, CHK, where CHK = CMD xor ARG.
- Enforces an inter-byte timeout, checks the frame, and presents validated CMD/ARG pairs to the decoder through a one-entry valid/ready output register.
- Reports receiver errors, timeouts, checksum failures and overruns as error pulses.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 64, maximum clk cycles allowed between consecutive bytes inside a frame (minimum 2).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- rx_data  input  8  byte from UART receiver; valid only when rx_done=1.
- rx_done  input  1  one-cycle pulse: byte received.
- rx_error  input  1  receiver reports parity/stop error on this byte; sampled only when rx_done=1.
- cmd  output  8  validated command byte.
- arg  output  8  validated argument byte.
- cmd_valid  output  1  cmd/arg hold a frame not yet accepted.
- cmd_ready  input  1  decoder accepts cmd/arg when cmd_valid=1 and cmd_ready=1.
- frame_err  output  1  one-cycle error pulse.
- err_code  output  2  cause, valid when frame_err=1: 01 rx error, 10 timeout, 11 checksum, 00 overrun.
- busy  output  1  1 whenever state is not WAIT_SYNC.

Behaviour:
- Reset values:
  - cmd=0, arg=0, cmd_valid=0, frame_err=0, err_code=0, busy=0.
  - State WAIT_SYNC; timeout counter 0; internal cmd/arg capture registers 0.
- States: WAIT_SYNC, GET_CMD, GET_ARG, GET_CHK. Each transition occurs on the clk edge where rx_done=1 and rx_error=0.
  - WAIT_SYNC: rx_data==SYNC_BYTE -> GET_CMD; any other byte is discarded silently with no error.
  - GET_CMD: capture rx_data as cmd -> GET_ARG. A SYNC_BYTE value here is ordinary data; there is no resynchronisation.
  - GET_ARG: capture rx_data as arg -> GET_CHK.
  - GET_CHK: always -> WAIT_SYNC.
    - If rx_data != (cmd xor arg): frame_err=1, err_code=11.
    - Otherwise the frame is delivered (see output register).
- rx_done=1 with rx_error=1, in any state including WAIT_SYNC:
  - Byte is discarded; frame_err=1, err_code=01; state -> WAIT_SYNC.
- Timeout (GET_CMD, GET_ARG and GET_CHK only):
  - Counter clears on every rx_done and on entry to WAIT_SYNC, and increments every cycle otherwise.
  - When the counter reaches TIMEOUT_CYCLES-1 with rx_done=0: frame_err=1, err_code=10, state -> WAIT_SYNC, partial frame dropped.
  - If rx_done arrives in the same cycle the counter would expire, the byte wins and no timeout occurs.
  - Counter width is clog2(TIMEOUT_CYCLES). It saturates and never wraps.
- Output register:
  - A good frame loads cmd/arg and sets cmd_valid=1 on the edge after the CHK byte's rx_done. Latency is 1 clk.
  - cmd_valid clears on the edge where cmd_valid=1 and cmd_ready=1.
  - cmd/arg stay stable while cmd_valid=1.
  - Good frame completes while cmd_valid=1 and cmd_ready=1 in the same cycle: the old frame is consumed, the new frame loads, and cmd_valid stays 1. No error.
  - Good frame completes while cmd_valid=1 and cmd_ready=0: the new frame is dropped and the held frame is kept; frame_err=1, err_code=00 (overrun).
- Pulse rules:
  - frame_err lasts exactly one cycle.
  - err_code holds its last value otherwise.
  - At most one error per cycle. Priority: rx error > checksum/overrun > timeout.
- reset asserted mid-frame or with cmd_valid=1: all state and outputs return to reset values on the next edge, and the held frame is lost.

Test Plan:
1. Bytes A5,12,34,26 with cmd_ready=1 -> cmd=12, arg=34, cmd_valid high for 1 cycle starting 1 clk after the 4th rx_done; frame_err never asserts.
2. Bytes A5,12,34,27 -> no cmd_valid; frame_err one-cycle pulse with err_code=11; a following valid frame A5,01,02,03 is delivered normally.
3. A5,12, then 64 idle cycles -> frame_err, err_code=10, busy drops. Repeat with the next byte arriving exactly on cycle 63 -> no timeout.
4. A5,12 then a byte with rx_error=1 -> frame_err, err_code=01, state WAIT_SYNC; next byte 34 is ignored; 00,FF,A5 preceding a frame -> only the frame after A5 is assembled.
5. Two good frames (cmd 10/arg 01, cmd 20/arg 02) with cmd_ready=0 -> first is held, second produces err_code=00 and cmd stays 10. Repeat with cmd_ready=1 asserted in the second frame's completion cycle -> cmd becomes 20 and there is no error.
6. reset asserted after A5,12 and while cmd_valid=1 -> all outputs 0 next cycle; a subsequent full frame decodes correctly.
